// File: rtl/id_operand_fwd_pkg.sv
// Shared constants, forwarding-port packing helpers and per-producer latencies
// for the decode-stage operand resolution block.
`ifndef ID_OPERAND_FWD_PKG_SV
`define ID_OPERAND_FWD_PKG_SV

// Slice source k out of a packed per-source bus of element width w.
`define FWD_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package id_operand_fwd_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [31:0] NOPRegAddr   = 32'h0000_0000;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // Cycles from issue until a long-latency result shows up on a forwarding port.
  localparam int LONG_LAT_LOAD = 3;
  localparam int LONG_LAT_MUL  = 3;
  localparam int LONG_LAT_DIV  = 3;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_e;

endpackage

`endif

// File: rtl/id_operand_fwd_fwd_mux.sv
// Single-operand priority bypass selector: immediate, $0, youngest matching
// forwarding source, then register file.
module fwd_mux
  import id_operand_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      read_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         rf_data_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  output logic [DATA_W-1:0]         data_o
);

  logic [NUM_FWD-1:0] hit;
  logic [DATA_W-1:0]  src_data [NUM_FWD];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_src
      assign hit[gi]      = (fwd_wreg_i[gi] == WriteEnable) &&
                            (`FWD_SLICE(fwd_wd_i, gi, ADDR_W) == addr_i);
      assign src_data[gi] = `FWD_SLICE(fwd_wdata_i, gi, DATA_W);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    data_o = rf_data_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit[k]) data_o = src_data[k];
    end
    if (addr_i == ADDR_W'(NOPRegAddr)) data_o = DATA_W'(ZeroWord);
    if (!read_i)                       data_o = imm_i;
  end

endmodule

// File: rtl/id_operand_fwd.sv
// Decode-stage operand resolution with a single-entry long-latency scoreboard
// and the ID/EX pipeline register.
module id_operand_fwd
  import id_operand_fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_FWD  = 2,
  parameter int LONG_LAT = LONG_LAT_LOAD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic                      reg1_read_i,
  input  logic                      reg2_read_i,
  input  logic [ADDR_W-1:0]         reg1_addr_i,
  input  logic [ADDR_W-1:0]         reg2_addr_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [ADDR_W-1:0]         wd_i,
  input  logic                      wreg_i,
  input  logic                      long_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      stallreq_o,
  output logic                      ex_valid_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [ADDR_W-1:0]         ex_wd_o,
  output logic                      ex_wreg_o
);

  localparam int CNT_W = $clog2(LONG_LAT + 1);

  logic [DATA_W-1:0] reg1_res, reg2_res;

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .read_i      (reg1_read_i),
    .addr_i      (reg1_addr_i),
    .rf_data_i   (reg1_data_i),
    .imm_i       (imm_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (reg1_res)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .read_i      (reg2_read_i),
    .addr_i      (reg2_addr_i),
    .rf_data_i   (reg2_data_i),
    .imm_i       (imm_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .data_o      (reg2_res)
  );

  // Scoreboard
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  sb_state_e         sb_state;
  logic              dep1, dep2, issue, sb_load;

  assign sb_state = (cnt_q != '0) ? SB_BUSY : SB_IDLE;
  assign dep1 = reg1_read_i && (reg1_addr_i == pend_addr_q) &&
                (pend_addr_q != ADDR_W'(NOPRegAddr));
  assign dep2 = reg2_read_i && (reg2_addr_i == pend_addr_q) &&
                (pend_addr_q != ADDR_W'(NOPRegAddr));

  // Only one long producer may be in flight, so a second long op also waits.
  assign stallreq_o = rst && id_valid_i && (sb_state == SB_BUSY) &&
                      (dep1 || dep2 || long_i);

  assign issue   = id_valid_i && !stallreq_o && !stall_i;
  assign sb_load = issue && long_i && (wreg_i == WriteEnable) &&
                   (wd_i != ADDR_W'(NOPRegAddr));

  always_comb begin
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    if (sb_load) begin
      cnt_d       = CNT_W'(LONG_LAT);
      pend_addr_d = wd_i;
    end else if (sb_state == SB_BUSY && !stall_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      pend_addr_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // ID/EX register
  logic              ex_valid_q, ex_valid_d;
  logic              ex_wreg_q, ex_wreg_d;
  logic [ADDR_W-1:0] ex_wd_q, ex_wd_d;
  logic [DATA_W-1:0] ex_reg1_q, ex_reg1_d;
  logic [DATA_W-1:0] ex_reg2_q, ex_reg2_d;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_wreg_d  = WriteDisable;
    ex_wd_d    = ADDR_W'(NOPRegAddr);
    ex_reg1_d  = DATA_W'(ZeroWord);
    ex_reg2_d  = DATA_W'(ZeroWord);
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (stall_i) begin
      ex_valid_d = ex_valid_q;
      ex_wreg_d  = ex_wreg_q;
      ex_wd_d    = ex_wd_q;
      ex_reg1_d  = ex_reg1_q;
      ex_reg2_d  = ex_reg2_q;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_wreg_d  = wreg_i;
      ex_wd_d    = wd_i;
      ex_reg1_d  = reg1_res;
      ex_reg2_d  = reg2_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_wreg_q  <= WriteDisable;
      ex_wd_q    <= '0;
      ex_reg1_q  <= '0;
      ex_reg2_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_wd_q    <= ex_wd_d;
      ex_reg1_q  <= ex_reg1_d;
      ex_reg2_q  <= ex_reg2_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_wreg_o  = ex_wreg_q;
  assign ex_wd_o    = ex_wd_q;
  assign ex_reg1_o  = ex_reg1_q;
  assign ex_reg2_o  = ex_reg2_q;

endmodule

// File: tb/tb_id_operand_fwd.sv
// Directed plus randomized checks of id_operand_fwd against a cycle-level
// behavioural model of operand resolution, interlock and ID/EX staging.
module tb_id_operand_fwd;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_FWD  = 2;
  localparam int LONG_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      id_valid, reg1_read, reg2_read;
  logic [ADDR_W-1:0]         reg1_addr, reg2_addr, wd;
  logic [DATA_W-1:0]         reg1_data, reg2_data, imm;
  logic                      wreg, long_op, stall, flush;
  logic [NUM_FWD-1:0]        fwd_wreg;
  logic [NUM_FWD*ADDR_W-1:0] fwd_wd;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic                      stallreq_o, ex_valid_o, ex_wreg_o;
  logic [DATA_W-1:0]         ex_reg1_o, ex_reg2_o;
  logic [ADDR_W-1:0]         ex_wd_o;

  id_operand_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
                   .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid),
    .reg1_read_i(reg1_read), .reg2_read_i(reg2_read),
    .reg1_addr_i(reg1_addr), .reg2_addr_i(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data), .imm_i(imm),
    .wd_i(wd), .wreg_i(wreg), .long_i(long_op),
    .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
    .stall_i(stall), .flush_i(flush), .stallreq_o(stallreq_o),
    .ex_valid_o(ex_valid_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: cycles left until the long result is forwardable, and its address.
  int                m_left = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_valid = 0, m_wreg = 0;
  logic [ADDR_W-1:0] m_wd = '0;
  logic [DATA_W-1:0] m_r1 = '0, m_r2 = '0;
  logic              seen_stall;

  function automatic logic [DATA_W-1:0] ref_operand(input logic rd, input logic [ADDR_W-1:0] a,
                                                    input logic [DATA_W-1:0] rf);
    if (!rd) return imm;
    if (a == 0) return '0;
    for (int k = 0; k < NUM_FWD; k++)
      if (fwd_wreg[k] && fwd_wd[k*ADDR_W +: ADDR_W] == a) return fwd_wdata[k*DATA_W +: DATA_W];
    return rf;
  endfunction

  function automatic logic ref_stall();
    if (!rst || !id_valid || m_left == 0) return 1'b0;
    if (long_op) return 1'b1;
    if (m_addr != 0 && reg1_read && reg1_addr == m_addr) return 1'b1;
    if (m_addr != 0 && reg2_read && reg2_addr == m_addr) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check the interlock mid-cycle, advance the model, check ID/EX after the edge.
  task automatic step();
    logic exp_stall, iss;
    #3;
    exp_stall  = ref_stall();
    seen_stall = stallreq_o;
    check("stallreq", stallreq_o, exp_stall);
    iss = rst && id_valid && !exp_stall && !stall;
    if (!rst) begin
      m_left = 0; m_addr = '0;
      m_valid = 0; m_wreg = 0; m_wd = '0; m_r1 = '0; m_r2 = '0;
    end else begin
      if (iss && long_op && wreg && wd != 0) begin
        m_left = LONG_LAT; m_addr = wd;
      end else if (m_left > 0 && !stall) begin
        m_left--;
      end
      if (flush || (!stall && !iss)) begin
        m_valid = 0; m_wreg = 0; m_wd = '0; m_r1 = '0; m_r2 = '0;
      end else if (!stall) begin
        m_valid = 1; m_wreg = wreg; m_wd = wd;
        m_r1 = ref_operand(reg1_read, reg1_addr, reg1_data);
        m_r2 = ref_operand(reg2_read, reg2_addr, reg2_data);
      end
    end
    @(posedge clk);
    #1;
    check("ex_valid", ex_valid_o, m_valid);
    check("ex_wreg", ex_wreg_o, m_wreg);
    check("ex_wd", ex_wd_o, m_wd);
    check("ex_reg1", ex_reg1_o, m_r1);
    check("ex_reg2", ex_reg2_o, m_r2);
  endtask

  task automatic zero_inputs();
    id_valid = 0; reg1_read = 0; reg2_read = 0; reg1_addr = '0; reg2_addr = '0;
    reg1_data = '0; reg2_data = '0; imm = '0; wd = '0; wreg = 0; long_op = 0;
    fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; stall = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    id_valid  = ($urandom_range(0, 7) != 0);
    reg1_read = $urandom_range(0, 1); reg2_read = ($urandom_range(0, 3) != 0);
    reg1_addr = ADDR_W'($urandom_range(0, 7)); reg2_addr = ADDR_W'($urandom_range(0, 7));
    reg1_data = $urandom; reg2_data = $urandom; imm = $urandom;
    wd = ADDR_W'($urandom_range(0, 7)); wreg = ($urandom_range(0, 3) != 0);
    long_op = ($urandom_range(0, 3) == 0);
    fwd_wreg = NUM_FWD'($urandom); fwd_wdata = {$urandom, $urandom};
    for (int k = 0; k < NUM_FWD; k++) fwd_wd[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
    stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 15) == 0);
  endtask

  // Wait out an interlock; returns how many cycles stallreq was seen.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!seen_stall) break;
      n++;
      if (!stall) check("bubble_valid", ex_valid_o, 0);
    end
  endtask

  task automatic issue_long_r8();
    zero_inputs();
    id_valid = 1; long_op = 1; wreg = 1; wd = 5'd8;
    step();
    check("long_issued", ex_valid_o, 1);
    long_op = 0; wd = 5'd9; reg1_read = 1; reg1_addr = 5'd8; reg1_data = 32'h1111;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd8}; fwd_wdata = {32'h0, 32'h0000CAFE};
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    zero_inputs();
    rst = 0;
    repeat (2) begin rand_inputs(); step(); check("rst_outputs_zero", {ex_valid_o, ex_wreg_o, ex_reg1_o}, 0); end
    rst = 1;

    // Forwarding priority and the register-file fall-through.
    zero_inputs();
    id_valid = 1; reg1_read = 1; reg1_addr = 5'd3; reg1_data = 32'h1234;
    fwd_wreg = 2'b11; fwd_wd = {5'd3, 5'd3}; fwd_wdata = {32'h0000_5555, 32'hAAAA_0000};
    step(); check("fwd_youngest", ex_reg1_o, 32'hAAAA_0000);
    fwd_wreg = 2'b10;
    step(); check("fwd_older", ex_reg1_o, 32'h0000_5555);
    fwd_wreg = 2'b00;
    step(); check("fwd_regfile", ex_reg1_o, 32'h1234);

    // $0 is never forwarded; disabled read takes the immediate.
    zero_inputs();
    id_valid = 1; reg2_read = 1; reg2_addr = 5'd0; reg2_data = 32'h77;
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'hFFFF_FFFF};
    step(); check("zero_guard", ex_reg2_o, 0);
    reg2_read = 0; imm = 32'h0000_BEEF;
    step(); check("imm_path", ex_reg2_o, 32'h0000_BEEF);

    // Load-use interlock.
    issue_long_r8();
    count_stalls(n);
    check("loaduse_stall_cycles", n, LONG_LAT);
    check("loaduse_fwd_data", ex_reg1_o, 32'h0000_CAFE);
    check("loaduse_issued", ex_valid_o, 1);

    // Downstream stall mid-wait stretches the interlock.
    issue_long_r8();
    step(); stall = 1; step(); step(); stall = 0;
    count_stalls(n);
    check("stretched_stall_cycles", n + 3, LONG_LAT + 2);
    check("stretched_fwd_data", ex_reg1_o, 32'h0000_CAFE);

    // Stall holds outputs.
    zero_inputs();
    id_valid = 1; reg1_read = 1; reg1_addr = 5'd4; reg1_data = 32'hD00D; wreg = 1; wd = 5'd4;
    step();
    stall = 1; reg1_data = 32'h9999; wd = 5'd6;
    step(); check("stall_hold_reg1", ex_reg1_o, 32'hD00D); check("stall_hold_wd", ex_wd_o, 4);

    // Flush with stall clears ID/EX but leaves the scoreboard counting from where it was.
    issue_long_r8();
    flush = 1; stall = 1;
    step(); check("flush_valid", ex_valid_o, 0); check("flush_wreg", ex_wreg_o, 0);
    flush = 0; stall = 0;
    count_stalls(n);
    check("flush_keeps_cnt", n, LONG_LAT);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) != 0);
      step();
    end
    rst = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_fwd.md
# id_operand_fwd

Parametrised operand-resolution and ID/EX staging block for the decode stage. It resolves both source operands through a priority bypass network of `NUM_FWD` forwarding sources plus the register file. A countdown scoreboard tracks one long-latency producer (load, mul/div) and raises a load-use interlock when a dependent instruction reaches decode. Results are registered into the ID/EX pipeline register with stall, bubble and flush control.

## Interface
Parameters:
- `DATA_W`, 32, operand/data width
- `ADDR_W`, 5, register address width
- `NUM_FWD`, 2, number of forwarding sources; index 0 is youngest (EX), higher index is older (MEM, WB…)
- `LONG_LAT`, 3, cycles after issue before a long-latency result is visible on a forwarding port; ≥1

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset; synchronous and active-low
- `id_valid_i`  in  1  decode holds a valid instruction
- `reg1_read_i`, `reg2_read_i`  in  1 each  operand read enables
- `reg1_addr_i`, `reg2_addr_i`  in  ADDR_W each  source register addresses
- `reg1_data_i`, `reg2_data_i`  in  DATA_W each  register file read data
- `imm_i`  in  DATA_W  immediate, substituted when the read enable is low
- `wd_i`  in  ADDR_W  destination address
- `wreg_i`  in  1  instruction writes a register
- `long_i`  in  1  result is long-latency
- `fwd_wreg_i`  in  NUM_FWD  per-source write enable
- `fwd_wd_i`  in  NUM_FWD*ADDR_W  per-source destination; source k at bits [k*ADDR_W +: ADDR_W]
- `fwd_wdata_i`  in  NUM_FWD*DATA_W  per-source data, same packing
- `stall_i`  in  1  downstream stall; freeze ID/EX
- `flush_i`  in  1  kill the ID/EX contents
- `stallreq_o`  out  1  interlock request to pipeline control (combinational)
- `ex_valid_o`  out  1  ID/EX holds a valid instruction
- `ex_reg1_o`, `ex_reg2_o`  out  DATA_W each  resolved operands
- `ex_wd_o`  out  ADDR_W  destination
- `ex_wreg_o`  out  1  write enable

## Operation
- Operand resolution, per operand, combinational, priority order:
  1. Read disabled → `imm_i`.
  2. Address 0 → zero. Address 0 is never forwarded and never causes a hazard.
  3. Lowest-index forwarding source k with `fwd_wreg_i[k]`=1 and a matching address → that source's data.
  4. Otherwise → register file data.
- Scoreboard: one entry `{pend_addr, cnt}`. Counter width is $clog2(LONG_LAT+1).
  - State IDLE: `cnt`=0.
  - State BUSY: `cnt`>0.
- Hazard. `stallreq_o`=1 when `id_valid_i`=1 and any of:
  - BUSY, and an enabled operand reads `pend_addr`≠0;
  - BUSY, and `long_i`=1 (only one long producer may be in flight).
- Issue: `id_valid_i`=1, `stallreq_o`=0 and `stall_i`=0.
- IDLE→BUSY: issue with `long_i`=1, `wreg_i`=1 and `wd_i`≠0. Load `cnt`=LONG_LAT and `pend_addr`=`wd_i`.
- BUSY: `cnt` decrements by 1 each cycle with `stall_i`=0 and holds when `stall_i`=1. It enters IDLE when it reaches 0.
- ID/EX update priority: `rst` low > `flush_i` > `stall_i` > issue > bubble.
  - `flush_i`: clear `ex_valid_o`, `ex_wreg_o`, `ex_wd_o`, and both operands to 0.
  - `stall_i`: hold all outputs.
  - Issue: load the resolved operands, `wd_i`, `wreg_i`, and `ex_valid_o`=1.
  - Otherwise (self-stall or no instruction): bubble, same values as flush.
- `flush_i` does not clear the scoreboard. A conservative stall of at most LONG_LAT cycles is accepted.
- Reset mid-operation: the scoreboard returns to IDLE and the ID/EX register clears. Any in-flight long op is forgotten.

## Timing
- Reset values: all outputs 0 and `cnt`=0. `stallreq_o`=0 under reset.
- Operand resolution and `stallreq_o` are combinational from the inputs and scoreboard state in the same cycle.
- The ID/EX outputs have 1-cycle latency: values issued in cycle N are visible after edge N.
- A dependent of a long op issued at edge N stalls while BUSY. It issues on the first cycle `cnt`=0, taking the result from a forwarding port.
- Simultaneous `flush_i` and `stall_i`: flush wins.
- Simultaneous long issue and `cnt` reaching 0: not possible. Issuing a long op requires IDLE.

## Structure
- Shared package/defines holds:
  - ZeroWord, NOPRegAddr, WriteEnable/WriteDisable;
  - forwarding-port packing macros;
  - LONG_LAT defaults per producer class.
- One sub-module, `fwd_mux`: a single-operand priority bypass selector parametrised by NUM_FWD. It is instantiated twice.
- Scoreboard and ID/EX register stay in the top level.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs → all outputs 0 and `stallreq_o`=0. Release → the first issue appears one cycle later.
- Forward priority: reg1_addr=3; fwd0 = {wreg=1, wd=3, 0xAAAA0000}; fwd1 = {wreg=1, wd=3, 0x5555}; regfile returns 0x1234 → `ex_reg1_o`=0xAAAA0000. With fwd0 wreg=0 → 0x5555.
- $0 guard: reg2_addr=0, fwd0 = {wreg=1, wd=0, 0xFFFFFFFF} → `ex_reg2_o`=0.
- Immediate path: reg2_read=0, `imm_i`=0x0000BEEF → `ex_reg2_o`=0x0000BEEF.
- Load-use, LONG_LAT=3: issue a long op with wd=8, then a consumer reads r8 →
  - `stallreq_o`=1 for 3 cycles, with a bubble (`ex_valid_o`=0) each cycle;
  - the consumer issues on the 4th cycle with fwd data 0xCAFE.
  - Repeat with `stall_i`=1 for 2 cycles mid-wait → the stall stretches to 5 cycles.
- Flush/stall: `stall_i`=1 holds the outputs unchanged. `flush_i`=1 together with `stall_i`=1 → next cycle `ex_valid_o`=0 and `ex_wreg_o`=0, and the scoreboard `cnt` is unchanged.
